// File: rtl/vga_pixel_arbiter.sv
// Round-robin owner arbiter for the shared VGA plotter port.
// Bursts end on last pixel, dropped request, or watchdog expiry.
module vga_pixel_arbiter #(
    parameter int MAX_BURST = 20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [2:0]  valid,
    input  logic [2:0]  last,
    input  logic [23:0] x_in,
    input  logic [20:0] y_in,
    input  logic [8:0]  colour_in,
    output logic [2:0]  grant,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        writeEn,
    output logic        busy,
    output logic        timeout
);

    localparam logic [15:0] LP_LIM = 16'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_owner;
    logic [1:0]  r_ptr;
    logic [15:0] r_cnt;
    logic [2:0]  r_grant;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;
    logic        r_we;
    logic        r_timeout;

    state_t      w_state_nxt;
    logic [1:0]  w_owner_nxt;
    logic [1:0]  w_ptr_nxt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  w_grant_nxt;
    logic [7:0]  w_x_nxt;
    logic [6:0]  w_y_nxt;
    logic [2:0]  w_colour_nxt;
    logic        w_we_nxt;
    logic        w_timeout_nxt;

    logic [1:0]  w_pick;
    logic        w_found;
    logic        w_oq;
    logic        w_ov;
    logic        w_ol;
    logic [7:0]  w_ox;
    logic [6:0]  w_oy;
    logic [2:0]  w_oc;
    logic        w_acc;
    logic        w_lrel;
    logic        w_wd;
    logic        w_rel;

    function automatic logic [1:0] f_wrap(input logic [1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= 3) s = s - 3;
        return s[1:0];
    endfunction

    // First requester at or after the pointer wins.
    always_comb begin
        w_pick  = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!w_found && req[f_wrap(r_ptr, k)]) begin
                w_pick  = f_wrap(r_ptr, k);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_oq = req[0];
        w_ov = valid[0];
        w_ol = last[0];
        w_ox = x_in[7:0];
        w_oy = y_in[6:0];
        w_oc = colour_in[2:0];
        case (r_owner)
            2'd1: begin
                w_oq = req[1];
                w_ov = valid[1];
                w_ol = last[1];
                w_ox = x_in[15:8];
                w_oy = y_in[13:7];
                w_oc = colour_in[5:3];
            end
            2'd2: begin
                w_oq = req[2];
                w_ov = valid[2];
                w_ol = last[2];
                w_ox = x_in[23:16];
                w_oy = y_in[20:14];
                w_oc = colour_in[8:6];
            end
            default: ;
        endcase
    end

    assign w_acc  = w_ov & w_oq;
    assign w_lrel = w_acc & w_ol;
    assign w_wd   = (r_cnt == LP_LIM);
    assign w_rel  = w_lrel | ~w_oq | w_wd;

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_colour_nxt  = r_colour;
        w_we_nxt      = 1'b0;
        w_timeout_nxt = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_owner_nxt = w_pick;
                    w_grant_nxt = 3'b001 << w_pick;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = S_OWN;
                end
            end
            S_OWN: begin
                if (w_acc) begin
                    w_x_nxt      = w_ox;
                    w_y_nxt      = w_oy;
                    w_colour_nxt = w_oc;
                    w_we_nxt     = 1'b1;
                end
                if (w_rel) begin
                    w_grant_nxt = 3'b000;
                    w_ptr_nxt   = (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
                    w_state_nxt = S_GAP;
                    // Only a pure watchdog expiry counts as a timeout.
                    if (w_wd && w_oq && !w_lrel) w_timeout_nxt = 1'b1;
                end else if (!w_wd) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_GAP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_owner   <= 2'd0;
            r_ptr     <= 2'd0;
            r_cnt     <= 16'd0;
            r_grant   <= 3'b000;
            r_x       <= 8'd0;
            r_y       <= 7'd0;
            r_colour  <= 3'd0;
            r_we      <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_colour  <= w_colour_nxt;
            r_we      <= w_we_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign grant   = r_grant;
    assign x       = r_x;
    assign y       = r_y;
    assign colour  = r_colour;
    assign writeEn = r_we;
    assign busy    = (r_state != S_IDLE);
    assign timeout = r_timeout;

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// Bench for vga_pixel_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level ownership model.
module tb_vga_pixel_arbiter;

    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req, valid, last;
    logic [23:0] x_in;
    logic [20:0] y_in;
    logic [8:0]  colour_in;
    logic [2:0]  grant;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn, busy, timeout;

    always #5 clk = ~clk;

    vga_pixel_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n),
        .req(req), .valid(valid), .last(last),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
        .grant(grant), .x(x), .y(y), .colour(colour),
        .writeEn(writeEn), .busy(busy), .timeout(timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: who owns the plotter, how long they have owned it,
    // and what the plotter outputs must show.
    int         m_own = -1;
    int         m_ptr = 0;
    int         m_cyc = 0;
    bit         m_gap = 0;
    bit         m_known = 0;
    bit         m_we = 0;
    bit         m_to = 0;
    logic [7:0] m_x = 0;
    logic [6:0] m_y = 0;
    logic [2:0] m_c = 0;

    task automatic model_step();
        int  o, pick;
        bit  acc, lr, wd;
        if (reset_n === 1'b0) begin
            m_own = -1; m_ptr = 0; m_cyc = 0; m_gap = 0;
            m_we = 0; m_to = 0; m_x = 0; m_y = 0; m_c = 0;
            m_known = 1;
        end else if (m_known) begin
            m_we = 0;
            if (m_own >= 0) begin
                o   = m_own;
                acc = valid[o] && req[o];
                lr  = acc && last[o];
                wd  = (m_cyc == MB - 1);
                if (acc) begin
                    m_we = 1;
                    m_x  = 8'(x_in >> (8 * o));
                    m_y  = 7'(y_in >> (7 * o));
                    m_c  = 3'(colour_in >> (3 * o));
                end
                if (lr || !req[o] || wd) begin
                    if (wd && req[o] && !lr) m_to = 1;
                    m_ptr = (o + 1) % 3;
                    m_own = -1;
                    m_gap = 1;
                end else begin
                    m_cyc++;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                pick = -1;
                for (int k = 0; k < 3; k++)
                    if (pick < 0 && req[(m_ptr + k) % 3])
                        pick = (m_ptr + k) % 3;
                if (pick >= 0) begin
                    m_own = pick;
                    m_cyc = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    int          nwr = 0;
    int          nff = 0;
    logic [17:0] wq[$];

    initial forever begin
        @(posedge clk);
        #1;
        if (writeEn === 1'b1) begin
            nwr++;
            if (x == 8'hFF) nff++;
            wq.push_back({x, y, colour});
        end
        if (m_known) begin
            chk("grant", grant,
                (m_own >= 0) ? 32'(1 << m_own) : 32'd0);
            chk("writeEn", writeEn, m_we);
            chk("busy", busy, (m_own >= 0) || m_gap);
            chk("timeout", timeout, m_to);
            chk("x", x, m_x);
            chk("y", y, m_y);
            chk("colour", colour, m_c);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_nz(output int z);
        z = 0;
        while (grant == 3'b000 && z < 20) begin
            step();
            z++;
        end
        chk("grant_wait", grant != 3'b000, 1);
    endtask

    task automatic idle(int n);
        req = 0; valid = 0; last = 0;
        repeat (n) step();
    endtask

    int z, o, n0;

    initial begin
        reset_n = 0; req = 3'b111; valid = 0; last = 0;
        x_in = 0; y_in = 0; colour_in = 0;
        step(); step();
        chk("rst_grant", grant, 0);
        chk("rst_out", {x, y, colour, writeEn, busy, timeout}, 0);
        reset_n = 1;
        step();
        chk("first_grant", grant, 3'b001);
        idle(4);

        // Single burst from requester 1
        req = 3'b010;
        wait_nz(z);
        chk("sb_grant", grant, 3'b010);
        wq.delete();
        for (int i = 0; i < 4; i++) begin
            valid = 3'b010;
            x_in = {8'd0, 8'(10 + i), 8'd0};
            y_in = {7'd0, 7'd20, 7'd0};
            colour_in = {3'd0, 3'b101, 3'd0};
            last = (i == 3) ? 3'b010 : 3'b000;
            step();
        end
        chk("sb_drop", grant, 0);
        idle(3);
        chk("sb_count", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++)
            chk("sb_pix", wq[i], {8'(10 + i), 7'd20, 3'b101});

        // Pointer should now favour requester 2
        req = 3'b111;
        wait_nz(z);
        chk("ptr2", grant, 3'b100);
        idle(4);

        // Round robin with 2-pixel bursts
        req = 3'b111;
        for (int b = 0; b < 4; b++) begin
            wait_nz(z);
            if (b > 0) chk("rr_gap", z, 2);
            chk("rr_grant", grant, 32'(1 << (b % 3)));
            o = b % 3;
            valid = 3'(1 << o);
            x_in = 24'($urandom);
            y_in = 21'($urandom);
            colour_in = 9'($urandom);
            step();
            last = 3'(1 << o);
            step();
            valid = 0; last = 0;
        end
        idle(4);

        // Non-owner isolation
        req = 3'b001;
        wait_nz(z);
        nff = 0; n0 = nwr;
        for (int i = 0; i < 3; i++) begin
            valid = 3'b101;
            x_in = {8'hFF, 8'h00, 8'h11};
            step();
        end
        idle(3);
        chk("iso_ff", nff, 0);
        chk("iso_cnt", nwr - n0, 3);

        // Owner drops request while valid
        req = 3'b100;
        wait_nz(z);
        n0 = nwr;
        valid = 3'b100; req = 3'b000;
        x_in = {8'h33, 16'h0};
        step();
        chk("drop_grant", grant, 0);
        idle(3);
        chk("drop_wr", nwr - n0, 0);
        chk("drop_to", timeout, 0);

        // Watchdog
        req = 3'b001;
        wait_nz(z);
        n0 = nwr;
        valid = 3'b001;
        x_in = 24'($urandom);
        z = 0;
        while (grant != 0 && z < 30) begin
            step();
            z++;
        end
        idle(2);
        chk("wd_writes", nwr - n0, MB);
        chk("wd_to", timeout, 1);
        req = 3'b010;
        wait_nz(z);
        valid = 3'b010; last = 3'b010;
        step();
        idle(3);
        chk("wd_sticky", timeout, 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < 3; i++) begin
                req[i]   = ($urandom_range(0, 99) < 85);
                valid[i] = ($urandom_range(0, 99) < 70);
                last[i]  = ($urandom_range(0, 99) < 25);
            end
            x_in = 24'($urandom);
            y_in = 21'($urandom);
            colour_in = 9'($urandom);
            step();
        end

        reset_n = 0; req = 0; valid = 0; last = 0;
        step();
        chk("end_to", timeout, 0);
        chk("end_grant", grant, 0);
        reset_n = 1;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pixel_arbiter.md
# vga_pixel_arbiter

Round-robin arbiter that shares the single VGA plotter port (x, y, colour, writeEn) between three pixel-drawing requesters: card frame drawer, symbol drawer, highlight/cursor drawer. Each requester gets exclusive ownership for a burst of pixels, ended by a last-pixel marker, by dropping its request, or by a watchdog. Sits between the drawing engines and the VGA adapter. It replaces the OR-ing of writeEn lines so concurrent drawers can no longer corrupt each other's pixels.

## Interface
- MAX_BURST, default 20000: maximum cycles one requester may own the plotter before forced release; legal range 2..65535.
- clk  in  1  system clock (CLOCK_50 at top level).
- reset_n  in  1  synchronous, active-low reset.
- req  in  3  per-requester ownership request; bit i = requester i.
- valid  in  3  per-requester pixel valid; honoured only for the current owner.
- last  in  3  per-requester last-pixel marker; qualified by valid.
- x_in  in  24  packed x coordinates, requester i at bits [8i+7:8i].
- y_in  in  21  packed y coordinates, requester i at bits [7i+6:7i].
- colour_in  in  9  packed colours, requester i at bits [3i+2:3i].
- grant  out  3  one-hot ownership, registered; all zero when no owner.
- x  out  8  plotter x, registered.
- y  out  7  plotter y, registered.
- colour  out  3  plotter colour, registered.
- writeEn  out  1  plotter write strobe, registered, high exactly one cycle per accepted pixel.
- busy  out  1  high while in S_OWN or S_GAP.
- timeout  out  1  sticky; set when any burst is force-released by the watchdog, cleared only by reset.

## Operation
- Reset (reset_n low at a clk edge): state S_IDLE; grant=0, x=0, y=0, colour=0, writeEn=0, busy=0, timeout=0; priority pointer ptr=0; burst counter=0. Reset mid-burst aborts the burst immediately with no further writes.
- S_IDLE: if req != 0, choose the first set bit scanning ptr, ptr+1, ptr+2 (mod 3). Register grant for that requester, clear the burst counter, go to S_OWN. If req == 0, stay in S_IDLE.
- S_OWN, owner o:
  - Pixel accepted iff valid[o] & req[o]. Next cycle: x/y/colour = owner's slice, writeEn=1. Otherwise writeEn=0 and x/y/colour hold their values.
  - Release when any of these is true: (valid[o] & last[o] & req[o]); !req[o]; burst counter == MAX_BURST-1.
  - On release: grant=0 next cycle; ptr=(o+1) mod 3; go to S_GAP. The pixel accepted in the release cycle is still written.
  - A watchdog release that coincides with a last-pixel release is a normal release; timeout is not set.
  - The burst counter increments every S_OWN cycle, whether or not valid is high, saturating at MAX_BURST-1.
- S_GAP: one turnaround cycle with grant=0; always goes to S_IDLE. Requests are ignored in this cycle.
- valid, last, x_in, y_in and colour_in from non-owners are ignored. last without valid is ignored.
- Round-robin fairness: with all three requesters continuously requesting, ownership order is 0,1,2,0,...

## Timing
- Request to grant: req sampled high in S_IDLE at edge N gives grant high after edge N+1.
- Pixel latency: one cycle. An accepted pixel at edge N appears on x/y/colour with writeEn=1 after edge N+1.
- Peak throughput: one pixel per cycle while owning.
- Release to grant low: one cycle. Minimum gap between bursts: grant low for 2 cycles (S_GAP, then S_IDLE arbitration).
- A requester must hold req until it sees grant. Dropping req before grant forfeits that arbitration without error.

## Test plan
- Reset: hold reset_n low for 2 cycles with req=3'b111 -> all outputs 0. First grant after release of reset is 3'b001.
- Single burst: requester 1 sends 4 pixels (x=10..13, y=20, colour=3'b101), last on the 4th -> writeEn high on 4 consecutive cycles with matching x/y/colour; grant 3'b010 drops one cycle after last; ptr moves to 2.
- Round robin: req=3'b111 held, every burst 2 pixels with last -> grant sequence 001,010,100,001. No writeEn from a non-owner; each hand-off has 2 cycles with grant=0.
- Non-owner isolation: requester 0 owns; requester 2 drives valid with x=8'hFF -> no write with x=8'hFF.
- Watchdog: MAX_BURST=8; requester 0 holds req, valid=1, never asserts last -> exactly 8 writes, grant drops, timeout=1 and stays 1 through later bursts until reset.
- Request drop: owner drops req while valid is high -> that pixel is not written; grant drops next cycle; timeout remains 0.
